// File: rtl/mem_block_copy_pkg.sv
// Shared memory-side definitions: copy engine state encoding and memory depth.
// Imported by the copy engine and by anything modelling the attached memory.
package mem_block_copy_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } copy_state_t;

    localparam int MEM_DEPTH_DEFAULT = 85;

endpackage : mem_block_copy_pkg

// File: rtl/mem_block_copy_if.sv
// Single-port word memory bus: address, write strobe/data, combinational read data.
// The copy engine is the master; the memory model is the slave.
interface mem_block_copy_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);

    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_write_data;
    logic              mem_write_enable;
    logic [DATA_W-1:0] mem_read_data;

    modport master (
        output mem_address,
        output mem_write_data,
        output mem_write_enable,
        input  mem_read_data
    );

    modport slave (
        input  mem_address,
        input  mem_write_data,
        input  mem_write_enable,
        output mem_read_data
    );

endinterface : mem_block_copy_if

// File: rtl/mem_block_copy.sv
// Word-by-word memory block copy (memmove semantics): one read cycle then one
// write cycle per word, with range rejection and overlap-safe direction choice.
module mem_block_copy
    import mem_block_copy_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_DEPTH = MEM_DEPTH_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W-1:0] length,
    output logic              busy,
    output logic              done,
    output logic              error,
    mem_block_copy_if.master  mem
);

    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(MEM_DEPTH);

    copy_state_t       state_reg;
    logic [ADDR_W-1:0] src_ptr_reg;
    logic [ADDR_W-1:0] dst_ptr_reg;
    logic [ADDR_W-1:0] count_reg;
    logic [DATA_W-1:0] data_reg;
    logic              desc_reg;
    logic              busy_reg;
    logic              done_reg;
    logic              error_reg;
    logic [ADDR_W-1:0] mem_address_reg;
    logic              mem_we_reg;

    // One extra bit on the end addresses so a request running past the top
    // of the address space cannot wrap around and slip through the check.
    logic [ADDR_W:0]   src_end;
    logic [ADDR_W:0]   dst_end;
    logic              range_bad;
    logic              go_desc;
    logic [ADDR_W-1:0] src_first;
    logic [ADDR_W-1:0] dst_first;
    logic [ADDR_W-1:0] src_next;
    logic [ADDR_W-1:0] dst_next;

    assign src_end   = {1'b0, src_addr} + {1'b0, length};
    assign dst_end   = {1'b0, dst_addr} + {1'b0, length};
    assign range_bad = (src_end > DEPTH_EXT) || (dst_end > DEPTH_EXT);
    // Destination starts inside the source block: copy top-down so no source
    // word is overwritten before it has been read.
    assign go_desc   = (src_addr < dst_addr) && ({1'b0, dst_addr} < src_end);
    assign src_first = go_desc ? (src_end[ADDR_W-1:0] - ADDR_W'(1)) : src_addr;
    assign dst_first = go_desc ? (dst_end[ADDR_W-1:0] - ADDR_W'(1)) : dst_addr;
    assign src_next  = desc_reg ? (src_ptr_reg - ADDR_W'(1)) : (src_ptr_reg + ADDR_W'(1));
    assign dst_next  = desc_reg ? (dst_ptr_reg - ADDR_W'(1)) : (dst_ptr_reg + ADDR_W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            src_ptr_reg     <= '0;
            dst_ptr_reg     <= '0;
            count_reg       <= '0;
            data_reg        <= '0;
            desc_reg        <= 1'b0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            error_reg       <= 1'b0;
            mem_address_reg <= '0;
            mem_we_reg      <= 1'b0;
        end else begin
            done_reg        <= 1'b0;
            error_reg       <= 1'b0;
            mem_we_reg      <= 1'b0;
            mem_address_reg <= '0;
            case (state_reg)
                ST_IDLE: begin
                    busy_reg <= 1'b0;
                    if (start) begin
                        busy_reg <= 1'b1;
                        if (range_bad || (length == '0)) begin
                            state_reg <= ST_DONE;
                            done_reg  <= 1'b1;
                            error_reg <= range_bad;
                        end else begin
                            state_reg       <= ST_READ;
                            src_ptr_reg     <= src_first;
                            dst_ptr_reg     <= dst_first;
                            count_reg       <= length;
                            desc_reg        <= go_desc;
                            mem_address_reg <= src_first;
                        end
                    end
                end
                ST_READ: begin
                    data_reg        <= mem.mem_read_data;
                    mem_address_reg <= dst_ptr_reg;
                    mem_we_reg      <= 1'b1;
                    state_reg       <= ST_WRITE;
                end
                ST_WRITE: begin
                    src_ptr_reg <= src_next;
                    dst_ptr_reg <= dst_next;
                    count_reg   <= count_reg - ADDR_W'(1);
                    if (count_reg == ADDR_W'(1)) begin
                        state_reg <= ST_DONE;
                        done_reg  <= 1'b1;
                    end else begin
                        state_reg       <= ST_READ;
                        mem_address_reg <= src_next;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign busy                 = busy_reg;
    assign done                 = done_reg;
    assign error                = error_reg;
    assign mem.mem_address      = mem_address_reg;
    assign mem.mem_write_enable = mem_we_reg;
    assign mem.mem_write_data   = mem_we_reg ? data_reg : '0;

endmodule : mem_block_copy
